// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, the transmitter state encoding
// (also used by the receiver) and a parity helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Even parity of the data byte, flipped when odd parity is selected.
    function automatic logic parity_of(input logic [UART_DATA_BITS-1:0] data,
                                       input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 and flags the last count.
// pre_tick flags the count just before the tick so the transmitter can
// register outputs that must line up with the final cycle of a bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic pre_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_COUNT  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

    logic [CW-1:0] count;

    assign tick     = (count == LAST_COUNT);
    assign pre_tick = (CLKS_PER_BIT > 1) && (count == PRE_COUNT);

    // Free-running bit-period counter, held at zero while cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional
// parity, one or two stop bits. tx_ready and done are raised for the last
// cycle of the final stop bit so a waiting byte starts with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   tx_if,
    output logic       otx,
    output logic       busy,
    output logic       done
);

    localparam logic       PAR_EN    = (PARITY_EN != 0);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);
    localparam logic       TWO_STOP  = (STOP_BITS == 2);
    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = TWO_STOP ? 3'd1 : 3'd0;

    tx_state_t                 state;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [2:0]                bit_idx;
    logic                      parity_bit;
    logic                      tx_ready_q;

    logic tick;
    logic pre_tick;
    logic baud_clear;
    logic accept;
    logic final_stop;
    logic entering_final_stop;
    logic last_cycle_next;

    assign baud_clear     = (state == IDLE);
    assign accept         = tx_if.tx_valid && tx_ready_q;
    assign tx_if.tx_ready = tx_ready_q;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .tick    (tick),
        .pre_tick(pre_tick)
    );

    // With one clock per bit the final stop bit is a single cycle, so its
    // arrival is detected from the transition into it rather than pre_tick.
    assign final_stop = (state == STOP) && (bit_idx == LAST_STOP);
    assign entering_final_stop = tick && (
        ((state == DATA) && (bit_idx == LAST_DATA) && !PAR_EN && !TWO_STOP) ||
        ((state == PARITY) && !TWO_STOP) ||
        ((state == STOP) && TWO_STOP && (bit_idx == 3'd0)));
    assign last_cycle_next = (CLKS_PER_BIT == 1) ? entering_final_stop
                                                 : (final_stop && pre_tick);

    // Frame sequencer: owns the line, the shift register and handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
            otx        <= IDLE_LEVEL;
            tx_ready_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= last_cycle_next;
            if (accept) begin
                shift_reg  <= tx_if.tx_data;
                parity_bit <= parity_of(tx_if.tx_data, PAR_ODD);
                bit_idx    <= '0;
                state      <= START;
                otx        <= START_BIT;
                tx_ready_q <= 1'b0;
                busy       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tx_ready_q <= 1'b1;
                    end
                    START: begin
                        if (tick) begin
                            state <= DATA;
                            otx   <= shift_reg[0];
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            shift_reg <= shift_reg >> 1;
                            if (bit_idx == LAST_DATA) begin
                                bit_idx <= '0;
                                if (PAR_EN) begin
                                    state <= PARITY;
                                    otx   <= parity_bit;
                                end else begin
                                    state <= STOP;
                                    otx   <= STOP_BIT;
                                end
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                otx     <= shift_reg[1];
                            end
                        end
                    end
                    PARITY: begin
                        if (tick) begin
                            state <= STOP;
                            otx   <= STOP_BIT;
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (bit_idx == LAST_STOP) begin
                                state   <= IDLE;
                                otx     <= IDLE_LEVEL;
                                busy    <= 1'b0;
                                bit_idx <= '0;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        otx   <= IDLE_LEVEL;
                        busy  <= 1'b0;
                    end
                endcase
            end
            if (last_cycle_next) begin
                tx_ready_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations side by side, random bytes checked
// cycle by cycle against a frame model built from the framing rules.
module tb_uart_tx;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] otx_w;
    logic [3:0] busy_w;
    logic [3:0] done_w;

    int checks = 0;
    int errors = 0;

    uart_tx_if if0();
    uart_tx_if if1();
    uart_tx_if if2();
    uart_tx_if if3();

    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .tx_if(if0), .otx(otx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .tx_if(if1), .otx(otx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .reset(reset), .tx_if(if2), .otx(otx_w[2]), .busy(busy_w[2]), .done(done_w[2]));
    uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .tx_if(if3), .otx(otx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

    always #5 clk = ~clk;

    // Configuration of each instance as seen by the model
    function automatic int cfg_cpb(input int sel);
        return (sel == 3) ? 1 : 4;
    endfunction

    function automatic bit cfg_par(input int sel);
        return (sel == 1) || (sel == 2);
    endfunction

    function automatic bit cfg_odd(input int sel);
        return (sel == 2);
    endfunction

    function automatic int cfg_stop(input int sel);
        return (sel == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int sel);
        return cfg_cpb(sel) * (9 + (cfg_par(sel) ? 1 : 0) + cfg_stop(sel));
    endfunction

    // Line level in a given bit slot of the frame carrying byte b
    function automatic logic model_bit(input int sel, input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (cfg_par(sel) && slot == 9) return logic'((($countones(b) % 2) == 1) ^ cfg_odd(sel));
        return 1'b1;
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return if0.tx_ready;
            1: return if1.tx_ready;
            2: return if2.tx_ready;
            default: return if3.tx_ready;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0: begin if0.tx_valid = v; if0.tx_data = d; end
            1: begin if1.tx_valid = v; if1.tx_data = d; end
            2: begin if2.tx_valid = v; if2.tx_data = d; end
            default: begin if3.tx_valid = v; if3.tx_data = d; end
        endcase
    endtask

    task automatic wait_ready(input int sel, input string tag);
        int n = 0;
        while (get_ready(sel) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (get_ready(sel) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready_timeout dut%0d: tx_ready=%b expected 1", tag, sel, get_ready(sel));
        end
    endtask

    // Send a list of bytes; valid is held across frames so they run back to back
    task automatic run_frames(input int sel, input logic [7:0] bytes[$], input bit noise, input string tag);
        int   len;
        logic exp_otx;
        logic exp_last;
        wait_ready(sel, tag);
        drive(sel, 1'b1, bytes[0]);
        for (int i = 0; i < bytes.size(); i++) begin
            @(posedge clk); #1;
            len = frame_len(sel);
            for (int k = 0; k < len; k++) begin
                exp_otx  = model_bit(sel, bytes[i], k / cfg_cpb(sel));
                exp_last = (k == len - 1);
                checks++;
                if (otx_w[sel] !== exp_otx) begin
                    errors++;
                    $display("[TB] FAIL %s otx dut%0d byte %02h cycle %0d: got %b expected %b", tag, sel, bytes[i], k, otx_w[sel], exp_otx);
                end
                checks++;
                if (done_w[sel] !== exp_last) begin
                    errors++;
                    $display("[TB] FAIL %s done dut%0d byte %02h cycle %0d: got %b expected %b", tag, sel, bytes[i], k, done_w[sel], exp_last);
                end
                checks++;
                if (get_ready(sel) !== exp_last) begin
                    errors++;
                    $display("[TB] FAIL %s tx_ready dut%0d byte %02h cycle %0d: got %b expected %b", tag, sel, bytes[i], k, get_ready(sel), exp_last);
                end
                checks++;
                if (busy_w[sel] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s busy dut%0d byte %02h cycle %0d: got %b expected 1", tag, sel, bytes[i], k, busy_w[sel]);
                end
                if (k < len - 1) begin
                    if (noise)
                        drive(sel, 1'($urandom_range(0, 1)), (k % 2 == 0) ? 8'h3C : 8'($urandom));
                    else
                        drive(sel, 1'b0, 8'($urandom));
                    @(posedge clk); #1;
                end else if (i + 1 < bytes.size()) begin
                    drive(sel, 1'b1, bytes[i+1]);
                end else begin
                    drive(sel, 1'b0, 8'($urandom));
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (otx_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || done_w[sel] !== 1'b0 || get_ready(sel) !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s idle dut%0d cycle %0d: otx=%b busy=%b done=%b ready=%b expected 1 0 0 1", tag, sel, k, otx_w[sel], busy_w[sel], done_w[sel], get_ready(sel));
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 8'h00);
        #1 reset = 1'b1;
        #1;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (otx_w[s] !== 1'b1 || get_ready(s) !== 1'b0 || busy_w[s] !== 1'b0 || done_w[s] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_values dut%0d: otx=%b ready=%b busy=%b done=%b expected 1 0 0 0", s, otx_w[s], get_ready(s), busy_w[s], done_w[s]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (get_ready(s) !== 1'b1) begin
                errors++;
                $display("[TB] FAIL ready_after_reset dut%0d: got %b expected 1", s, get_ready(s));
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'hA5);
        run_frames(0, q, 1'b0, "basic_a5");
        for (int n = 0; n < 3; n++) begin
            q = {};
            q.push_back(8'($urandom));
            run_frames(0, q, 1'b0, "basic_rand");
        end
    endtask

    task automatic test_parity();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'hA5);
        q.push_back(8'h07);
        q.push_back(8'($urandom));
        run_frames(1, q, 1'b0, "parity_even");
        q = {};
        q.push_back(8'hA5);
        q.push_back(8'($urandom));
        run_frames(2, q, 1'b0, "parity_odd");
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'($urandom));
        run_frames(0, q, 1'b0, "b2b");
    endtask

    task automatic test_backpressure();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        run_frames(0, q, 1'b1, "backpressure");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic [7:0] q[$];
        b = 8'($urandom) & 8'hF7;
        wait_ready(0, "midreset");
        drive(0, 1'b1, b);
        @(posedge clk); #1;
        drive(0, 1'b0, 8'($urandom));
        repeat (17) begin
            @(posedge clk); #1;
        end
        checks++;
        if (otx_w[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset data_bit3 byte %02h: otx=%b expected 0", b, otx_w[0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (otx_w[0] !== 1'b1 || get_ready(0) !== 1'b0 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset async: otx=%b ready=%b busy=%b done=%b expected 1 0 0 0", otx_w[0], get_ready(0), busy_w[0], done_w[0]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (get_ready(0) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset ready_before_edge: got %b expected 0", get_ready(0));
        end
        @(posedge clk); #1;
        checks++;
        if (get_ready(0) !== 1'b1 || otx_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset recover: ready=%b otx=%b done=%b expected 1 1 0", get_ready(0), otx_w[0], done_w[0]);
        end
        q = {};
        q.push_back(8'h81);
        run_frames(0, q, 1'b0, "after_reset_81");
    endtask

    task automatic test_edge_config();
        logic [7:0] q[$];
        q = {};
        q.push_back(8'h55);
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        run_frames(3, q, 1'b0, "cpb1_stop2");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_edge_config();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
